// File: rtl/hilo_mul_seq_pkg.sv
// Shared constants for the HI/LO multiply sequencer: func codes, state encoding, default width.
package hilo_mul_seq_pkg;

  localparam int unsigned WidthDefault = 32;

  localparam logic [5:0] FuncMult = 6'b011000;
  localparam logic [5:0] FuncMfhi = 6'b010000;
  localparam logic [5:0] FuncMflo = 6'b010010;
  localparam logic [5:0] FuncMthi = 6'b010001;
  localparam logic [5:0] FuncMtlo = 6'b010011;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

  function automatic logic is_hl_func(input logic [5:0] f);
    return (f == FuncMult) || (f == FuncMfhi) || (f == FuncMflo) ||
           (f == FuncMthi) || (f == FuncMtlo);
  endfunction

endpackage

// File: rtl/hilo_mul_seq_mul_step.sv
// One radix-2 shift-add iteration: conditionally add the multiplicand into the upper
// accumulator half, then shift {acc, multiplier} right by one.
module mul_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   multiplicand,
  output logic [2*WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0]   multiplier_next
);

  // One extra bit keeps the carry of the add; it lands in the accumulator MSB after the shift.
  logic [WIDTH:0] upper;

  assign upper = multiplier[0] ? ({1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, multiplicand})
                               : {1'b0, acc[2*WIDTH-1:WIDTH]};

  assign acc_next        = {upper, acc[WIDTH-1:1]};
  assign multiplier_next = {acc[0], multiplier[WIDTH-1:1]};

endmodule

// File: rtl/hilo_mul_seq.sv
// HI/LO register owner and sequencer for MULT/MFHI/MFLO/MTHI/MTLO; stalls HI/LO
// instructions while an iterative signed multiply is in flight.
module hilo_mul_seq
  import hilo_mul_seq_pkg::*;
#(
  parameter int unsigned WIDTH     = WidthDefault,
  parameter bit          FAST_ZERO = 1'b1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             op_valid,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e             state_q;
  logic [2*WIDTH-1:0] acc_q, acc_step;
  logic [WIDTH-1:0]   mplier_q, mplier_step, mcand_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [WIDTH-1:0]   rs_mag, rt_mag;
  logic [CntW-1:0]    cnt_q;
  logic               neg_q;
  logic               is_hl, accept, zero_op;

  assign is_hl  = op_valid && is_hl_func(func);
  assign busy   = (state_q != StIdle);
  assign stall  = is_hl && busy;
  assign accept = is_hl && !busy;

  // Unsigned magnitudes: the most negative value maps to 2^(WIDTH-1), which still fits.
  assign rs_mag  = rs_data[WIDTH-1] ? -rs_data : rs_data;
  assign rt_mag  = rt_data[WIDTH-1] ? -rt_data : rt_data;
  assign zero_op = FAST_ZERO && ((rs_data == '0) || (rt_data == '0));

  assign hi = hi_q;
  assign lo = lo_q;

  always_comb begin
    rd_data = '0;
    if (func == FuncMfhi) begin
      rd_data = hi_q;
    end else if (func == FuncMflo) begin
      rd_data = lo_q;
    end
  end

  mul_step #(
    .WIDTH(WIDTH)
  ) u_mul_step (
    .acc            (acc_q),
    .multiplier     (mplier_q),
    .multiplicand   (mcand_q),
    .acc_next       (acc_step),
    .multiplier_next(mplier_step)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            case (func)
              FuncMult: begin
                mcand_q  <= rs_mag;
                mplier_q <= rt_mag;
                neg_q    <= rs_data[WIDTH-1] ^ rt_data[WIDTH-1];
                acc_q    <= '0;
                cnt_q    <= '0;
                state_q  <= zero_op ? StDone : StRun;
              end
              FuncMthi: hi_q <= rs_data;
              FuncMtlo: lo_q <= rs_data;
              default: ;
            endcase
          end
        end
        StRun: begin
          acc_q    <= acc_step;
          mplier_q <= mplier_step;
          cnt_q    <= cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          {hi_q, lo_q} <= neg_q ? -acc_q : acc_q;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
